// File: rtl/branch_hazard_ctrl.sv
// Branch-lane hazard/flush controller: load-use scoreboard, stall/bubble
// on RAW hazards, fetch redirect and fixed-length flush on taken branches.
module branch_hazard_ctrl #(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned LOAD_LAT     = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_is_nop,
  input  logic        id_is_jmp,
  input  logic        id_is_imm_type,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ld_issue_valid,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ex_branch_resolved,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_target,
  output logic        stall,
  output logic        bubble,
  output logic        flush_if,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [2:0] pend [NUM_REGS];
  logic       hazard;
  logic       rs2_used;
  logic       stall_inc;

  // Per-register pending counters; a new load overrides the decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
    end else begin
      pend[0] <= '0;
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (ld_issue_valid && (32'(ld_issue_rd) == r)) begin
          pend[r] <= 3'(LOAD_LAT);
        end else if (pend[r] != '0) begin
          pend[r] <= pend[r] - 3'd1;
        end
      end
    end
  end

  assign rs2_used = !id_is_imm_type && !id_is_jmp;
  assign hazard   = id_valid && !id_is_nop &&
                    ((pend[id_rs1] != '0) || (rs2_used && (pend[id_rs2] != '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      flush_cnt    <= '0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (stall_inc && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    flush_cnt_nxt  = flush_cnt;
    stall          = 1'b0;
    bubble         = 1'b0;
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall_inc      = 1'b0;
    case (state)
      RUN, STALL: begin
        if (ex_branch_resolved && ex_branch_taken) begin
          redirect_valid = 1'b1;
          redirect_pc    = ex_target;
          flush_if       = 1'b1;
          bubble         = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt = RUN;
          end
        end else if (hazard) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          stall_inc = 1'b1;
          state_nxt = STALL;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        flush_if      = 1'b1;
        bubble        = 1'b1;
        flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt_nxt == '0) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: per-cycle vector table fed
// through an expectation queue, plus a reset-during-flush sequence.
module tb_branch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_nop, id_is_jmp, id_is_imm_type;
  logic [4:0]  id_rs1, id_rs2;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ex_branch_resolved, ex_branch_taken;
  logic [31:0] ex_target;
  logic        stall, bubble, flush_if, redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_hazard_ctrl #(
    .NUM_REGS    (32),
    .LOAD_LAT    (2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid          (id_valid),
    .id_is_nop         (id_is_nop),
    .id_is_jmp         (id_is_jmp),
    .id_is_imm_type    (id_is_imm_type),
    .id_rs1            (id_rs1),
    .id_rs2            (id_rs2),
    .ld_issue_valid    (ld_issue_valid),
    .ld_issue_rd       (ld_issue_rd),
    .ex_branch_resolved(ex_branch_resolved),
    .ex_branch_taken   (ex_branch_taken),
    .ex_target         (ex_target),
    .stall             (stall),
    .bubble            (bubble),
    .flush_if          (flush_if),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .ctrl_state        (ctrl_state),
    .stall_cycles      (stall_cycles)
  );

  typedef struct {
    int          tag;
    logic        ld_v;
    logic [4:0]  ld_rd;
    logic        id_v, nop, jmp, imm;
    logic [4:0]  rs1, rs2;
    logic        br, tk;
    logic [31:0] tgt;
    logic        e_stall, e_bubble, e_flush, e_rv;
    logic [31:0] e_rpc;
    logic [1:0]  e_state;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   next_tag = 0;

  function automatic vec_t mk(
    input logic ld_v, input logic [4:0] ld_rd,
    input logic id_v, input logic nop, input logic jmp, input logic imm,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic br, input logic tk, input logic [31:0] tgt,
    input logic e_stall, input logic e_bubble, input logic e_flush,
    input logic e_rv, input logic [31:0] e_rpc,
    input logic [1:0] e_state, input logic [15:0] e_sc);
    vec_t v;
    v.tag = 0;
    v.ld_v = ld_v; v.ld_rd = ld_rd;
    v.id_v = id_v; v.nop = nop; v.jmp = jmp; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2;
    v.br = br; v.tk = tk; v.tgt = tgt;
    v.e_stall = e_stall; v.e_bubble = e_bubble; v.e_flush = e_flush;
    v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_state = e_state; v.e_sc = e_sc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    id_valid = 1'b0; id_is_nop = 1'b0; id_is_jmp = 1'b0; id_is_imm_type = 1'b0;
    id_rs1 = '0; id_rs2 = '0;
    ld_issue_valid = 1'b0; ld_issue_rd = '0;
    ex_branch_resolved = 1'b0; ex_branch_taken = 1'b0; ex_target = '0;
  endtask

  // Drive one cycle, queue its expectation, check it at the falling edge.
  task automatic run_vec(input vec_t v_in);
    vec_t v;
    vec_t e;
    v = v_in;
    v.tag = next_tag;
    next_tag++;
    ld_issue_valid = v.ld_v; ld_issue_rd = v.ld_rd;
    id_valid = v.id_v; id_is_nop = v.nop; id_is_jmp = v.jmp; id_is_imm_type = v.imm;
    id_rs1 = v.rs1; id_rs2 = v.rs2;
    ex_branch_resolved = v.br; ex_branch_taken = v.tk; ex_target = v.tgt;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("v%0d.stall", e.tag), 32'(stall), 32'(e.e_stall));
      check($sformatf("v%0d.bubble", e.tag), 32'(bubble), 32'(e.e_bubble));
      check($sformatf("v%0d.flush_if", e.tag), 32'(flush_if), 32'(e.e_flush));
      check($sformatf("v%0d.redirect_valid", e.tag), 32'(redirect_valid), 32'(e.e_rv));
      check($sformatf("v%0d.redirect_pc", e.tag), redirect_pc, e.e_rpc);
      check($sformatf("v%0d.ctrl_state", e.tag), 32'(ctrl_state), 32'(e.e_state));
      check($sformatf("v%0d.stall_cycles", e.tag), 32'(stall_cycles), 32'(e.e_sc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, ".stall"}, 32'(stall), 32'd0);
    check({nm, ".bubble"}, 32'(bubble), 32'd0);
    check({nm, ".flush_if"}, 32'(flush_if), 32'd0);
    check({nm, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
    check({nm, ".redirect_pc"}, redirect_pc, 32'd0);
    check({nm, ".ctrl_state"}, 32'(ctrl_state), 32'd0);
    check({nm, ".stall_cycles"}, 32'(stall_cycles), 32'd0);
  endtask

  initial begin
    //             ld  rd  idv nop jmp imm rs1 rs2 br tk tgt        | st bu fl rv rpc        cs sc
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 0)); // idle
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 5, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 0)); // same-cycle load
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 32'h0,       1, 1, 0, 0, 32'h0,      0, 0)); // hazard 1
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 32'h0,       1, 1, 0, 0, 32'h0,      1, 1)); // hazard 2
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 5, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      1, 2)); // cleared
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 2));
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 3, 5, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 2)); // imm ignores rs2
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 3, 5, 0, 0, 32'h0,       1, 1, 0, 0, 32'h0,      0, 2)); // rs2 hazard
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 3, 5, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      1, 3)); // jmp, r0 load
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 3)); // r0 never pending
    vecs.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 3));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 5, 5, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 3)); // nop
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5, 5, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 3)); // not valid
    vecs.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 0, 0, 0, 32'h0,       1, 1, 0, 0, 32'h0,      0, 3)); // hazard
    vecs.push_back(mk(1, 9, 1, 0, 0, 0, 9, 0, 1, 1, 32'h1040,    0, 1, 1, 1, 32'h1040,   1, 4)); // branch wins
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 9, 0, 1, 1, 32'h2000,    0, 1, 1, 0, 32'h0,      2, 4)); // 2nd ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       0, 0, 0, 0, 32'h0,      0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h55,      0, 0, 0, 0, 32'h0,      0, 4)); // not taken

    rst = 1'b0;
    drive_idle();
    #1;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Reset asserted mid-flush with r7 pending must abandon both.
    run_vec(mk(1, 7, 0, 0, 0, 0, 0, 0, 1, 1, 32'hABC, 0, 1, 1, 1, 32'hABC, 0, 4));
    drive_idle();
    #1;
    check("pre_reset.ctrl_state", 32'(ctrl_state), 32'd2);
    check("pre_reset.flush_if", 32'(flush_if), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("mid_flush_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_vec(mk(0, 0, 1, 0, 0, 0, 7, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
    run_vec(mk(0, 0, 1, 0, 0, 0, 7, 7, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
